// File: rtl/sram_arbiter_if.sv
// Shared SRAM request bus: CPU and DMA initiator ports, the single SRAM port,
// and the DMA stall counter. Arbiter uses the slave side, environment the master side.
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_di;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_di;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] sram_ADDR;
    logic [DATA_W-1:0] sram_DI;
    logic              sram_EN;
    logic              sram_WE;
    logic [DATA_W-1:0] sram_DO;

    logic [15:0]       stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_di,
        input  dma_req, dma_we, dma_addr, dma_di,
        input  sram_DO,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output sram_ADDR, sram_DI, sram_EN, sram_WE,
        output stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_di,
        output dma_req, dma_we, dma_addr, dma_di,
        output sram_DO,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  sram_ADDR, sram_DI, sram_EN, sram_WE,
        input  stall_cnt
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-initiator SRAM arbiter: fixed CPU priority with a DMA starvation guard,
// single-cycle read return routed back to the initiator that issued the read.
module sram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          reset,
    sram_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

    logic [3:0]  starve_cnt;
    logic [15:0] stall_q;
    owner_e      rd_owner;
    owner_e      rd_owner_nxt;
    logic        force_dma;
    logic        cpu_gnt;
    logic        dma_gnt;
    logic        dma_stall;

    // Grants are gated by reset so nothing reaches the SRAM while held in reset
    always_comb begin
        force_dma = bus.dma_req && (starve_cnt == LIMIT);
        cpu_gnt   = reset && bus.cpu_req && !force_dma;
        dma_gnt   = reset && bus.dma_req && !cpu_gnt;
        dma_stall = bus.dma_req && !dma_gnt;
    end

    always_comb begin
        bus.sram_WE   = 1'b0;
        bus.sram_ADDR = '0;
        bus.sram_DI   = '0;
        rd_owner_nxt  = OWN_NONE;
        unique case (1'b1)
            cpu_gnt: begin
                bus.sram_WE   = bus.cpu_we;
                bus.sram_ADDR = bus.cpu_addr;
                bus.sram_DI   = bus.cpu_di;
                rd_owner_nxt  = bus.cpu_we ? OWN_NONE : OWN_CPU;
            end
            dma_gnt: begin
                bus.sram_WE   = bus.dma_we;
                bus.sram_ADDR = bus.dma_addr;
                bus.sram_DI   = bus.dma_di;
                rd_owner_nxt  = bus.dma_we ? OWN_NONE : OWN_DMA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            stall_q    <= '0;
            rd_owner   <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
            if (dma_stall) begin
                if (starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + 4'd1;
                if (stall_q != 16'hFFFF)
                    stall_q <= stall_q + 16'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    always_comb begin
        bus.sram_EN    = cpu_gnt | dma_gnt;
        bus.cpu_gnt    = cpu_gnt;
        bus.dma_gnt    = dma_gnt;
        bus.cpu_rvalid = (rd_owner == OWN_CPU);
        bus.dma_rvalid = (rd_owner == OWN_DMA);
        bus.cpu_rdata  = (rd_owner == OWN_CPU) ? bus.sram_DO : '0;
        bus.dma_rdata  = (rd_owner == OWN_DMA) ? bus.sram_DO : '0;
        bus.stall_cnt  = stall_q;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic scored
// against a transaction-level arbitration and memory model.
module tb_sram_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errs  = 0;
    int   checks = 0;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // SRAM model, fed from values captured mid-cycle
    logic [DW-1:0] sram_mem [int];
    logic [DW-1:0] ref_mem [int];
    logic          s_en, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_di;

    always @(negedge clk) begin
        s_en   <= bus.sram_EN;
        s_we   <= bus.sram_WE;
        s_addr <= bus.sram_ADDR;
        s_di   <= bus.sram_DI;
    end

    always @(posedge clk) begin
        if (s_en === 1'b1) begin
            if (s_we) sram_mem[int'(s_addr)] = s_di;
            else bus.sram_DO <= sram_mem.exists(int'(s_addr)) ? sram_mem[int'(s_addr)] : '0;
        end
    end

    // Reference model: winner 0=none 1=cpu 2=dma
    int            m_wait, m_stall, m_pend, win;
    logic [DW-1:0] m_pdata;
    logic          e_cgnt, e_dgnt, e_en, e_we, e_crv, e_drv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_di, e_crd, e_drd;

    function automatic logic [DW-1:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic m_clear();
        m_wait = 0; m_stall = 0; m_pend = 0; m_pdata = '0; win = 0;
    endtask

    task automatic set_in(input bit cr, input bit cw, input logic [AW-1:0] ca,
                          input logic [DW-1:0] cd, input bit dr, input bit dw,
                          input logic [AW-1:0] da, input logic [DW-1:0] dd);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_di = cd;
        bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_di = dd;
    endtask

    task automatic eval();
        @(negedge clk);
        if (!reset) win = 0;
        else if (bus.dma_req && m_wait >= LIM) win = 2;
        else if (bus.cpu_req) win = 1;
        else if (bus.dma_req) win = 2;
        else win = 0;
        e_cgnt = (win == 1);
        e_dgnt = (win == 2);
        e_en   = (win != 0);
        e_we   = (win == 1) ? bus.cpu_we : (win == 2) ? bus.dma_we : 1'b0;
        e_addr = (win == 1) ? bus.cpu_addr : (win == 2) ? bus.dma_addr : '0;
        e_di   = (win == 1) ? bus.cpu_di : (win == 2) ? bus.dma_di : '0;
        e_crv  = (m_pend == 1);
        e_drv  = (m_pend == 2);
        e_crd  = (m_pend == 1) ? m_pdata : '0;
        e_drd  = (m_pend == 2) ? m_pdata : '0;
    endtask

    task automatic adv();
        if (reset) begin
            if (bus.dma_req && win != 2) begin
                m_wait  = (m_wait < LIM) ? m_wait + 1 : LIM;
                m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            end else begin
                m_wait = 0;
            end
            m_pend = (win != 0 && !e_we) ? win : 0;
            if (m_pend != 0) m_pdata = ref_rd(int'(e_addr));
            if (win != 0 && e_we) ref_mem[int'(e_addr)] = e_di;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_clear();
        set_in(1, 0, 16'h0005, '0, 1, 0, 16'h0006, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        eval();
        checks++; if (bus.cpu_gnt !== 1'b0) begin errs++; $display("FAIL rst_cpu_gnt got=%b exp=0", bus.cpu_gnt); end
        checks++; if (bus.dma_gnt !== 1'b0) begin errs++; $display("FAIL rst_dma_gnt got=%b exp=0", bus.dma_gnt); end
        checks++; if (bus.sram_EN !== 1'b0) begin errs++; $display("FAIL rst_en got=%b exp=0", bus.sram_EN); end
        checks++; if (bus.sram_ADDR !== '0) begin errs++; $display("FAIL rst_addr got=%h exp=0", bus.sram_ADDR); end
        checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b00) begin errs++; $display("FAIL rst_rvalid got=%b exp=00", {bus.cpu_rvalid, bus.dma_rvalid}); end
        checks++; if (bus.cpu_rdata !== '0 || bus.dma_rdata !== '0) begin errs++; $display("FAIL rst_rdata got=%h/%h exp=0", bus.cpu_rdata, bus.dma_rdata); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errs++; $display("FAIL rst_stall got=%0d exp=0", bus.stall_cnt); end
        adv();
        reset = 1'b1;
        eval();
        checks++; if (bus.cpu_gnt !== 1'b1) begin errs++; $display("FAIL rel_cpu_gnt got=%b exp=1", bus.cpu_gnt); end
        checks++; if (bus.dma_gnt !== 1'b0) begin errs++; $display("FAIL rel_dma_gnt got=%b exp=0", bus.dma_gnt); end
        adv();
    endtask

    task automatic test_cpu_read();
        sram_mem[16] = 32'hDEADBEEF;
        ref_mem[16]  = 32'hDEADBEEF;
        set_in(1, 0, 16'h0010, '0, 0, 0, '0, '0);
        eval();
        checks++; if (bus.cpu_gnt !== 1'b1) begin errs++; $display("FAIL rd_gnt got=%b exp=1", bus.cpu_gnt); end
        checks++; if ({bus.sram_EN, bus.sram_WE} !== 2'b10) begin errs++; $display("FAIL rd_en_we got=%b exp=10", {bus.sram_EN, bus.sram_WE}); end
        checks++; if (bus.sram_ADDR !== 16'h0010) begin errs++; $display("FAIL rd_addr got=%h exp=0010", bus.sram_ADDR); end
        adv();
        set_in(0, 0, '0, '0, 0, 0, '0, '0);
        eval();
        checks++; if (bus.cpu_rvalid !== 1'b1) begin errs++; $display("FAIL rd_rvalid got=%b exp=1", bus.cpu_rvalid); end
        checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rd_data got=%h exp=deadbeef", bus.cpu_rdata); end
        checks++; if (bus.dma_rvalid !== 1'b0) begin errs++; $display("FAIL rd_dma_rvalid got=%b exp=0", bus.dma_rvalid); end
        adv();
    endtask

    task automatic test_dma_write();
        set_in(0, 0, '0, '0, 1, 1, 16'h0020, 32'h12345678);
        eval();
        checks++; if (bus.dma_gnt !== 1'b1) begin errs++; $display("FAIL wr_gnt got=%b exp=1", bus.dma_gnt); end
        checks++; if (bus.sram_WE !== 1'b1) begin errs++; $display("FAIL wr_we got=%b exp=1", bus.sram_WE); end
        checks++; if (bus.sram_DI !== 32'h12345678) begin errs++; $display("FAIL wr_di got=%h exp=12345678", bus.sram_DI); end
        adv();
        set_in(1, 0, 16'h0020, '0, 0, 0, '0, '0);
        eval();
        checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b00) begin errs++; $display("FAIL wr_no_rsp got=%b exp=00", {bus.cpu_rvalid, bus.dma_rvalid}); end
        adv();
        set_in(0, 0, '0, '0, 0, 0, '0, '0);
        eval();
        checks++; if (bus.cpu_rdata !== 32'h12345678) begin errs++; $display("FAIL wr_readback got=%h exp=12345678", bus.cpu_rdata); end
        adv();
    endtask

    task automatic test_starvation();
        int s0;
        s0 = m_stall;
        set_in(1, 1, 16'h0030, 32'h1, 1, 1, 16'h0031, 32'h2);
        for (int i = 0; i < 15; i++) begin
            eval();
            checks++;
            if ({bus.cpu_gnt, bus.dma_gnt} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin
                errs++; $display("FAIL starve_gnt cyc=%0d got=%b exp=%b", i, {bus.cpu_gnt, bus.dma_gnt}, (i % 5 == 4) ? 2'b01 : 2'b10);
            end
            adv();
        end
        set_in(0, 0, '0, '0, 0, 0, '0, '0);
        eval();
        checks++; if (int'(bus.stall_cnt) !== s0 + 12) begin errs++; $display("FAIL starve_stall got=%0d exp=%0d", bus.stall_cnt, s0 + 12); end
        adv();
    endtask

    task automatic test_alternating();
        logic [DW-1:0] d1, d2;
        d1 = $urandom; d2 = $urandom;
        sram_mem[1] = d1; ref_mem[1] = d1;
        sram_mem[2] = d2; ref_mem[2] = d2;
        set_in(1, 0, 16'h0001, '0, 0, 0, '0, '0);
        eval();
        adv();
        set_in(0, 0, '0, '0, 1, 0, 16'h0002, '0);
        eval();
        checks++; if (bus.dma_gnt !== 1'b1) begin errs++; $display("FAIL alt_dma_gnt got=%b exp=1", bus.dma_gnt); end
        checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b10) begin errs++; $display("FAIL alt_rv1 got=%b exp=10", {bus.cpu_rvalid, bus.dma_rvalid}); end
        checks++; if (bus.cpu_rdata !== d1 || bus.dma_rdata !== '0) begin errs++; $display("FAIL alt_rd1 got=%h/%h exp=%h/0", bus.cpu_rdata, bus.dma_rdata, d1); end
        adv();
        set_in(0, 0, '0, '0, 0, 0, '0, '0);
        eval();
        checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b01) begin errs++; $display("FAIL alt_rv2 got=%b exp=01", {bus.cpu_rvalid, bus.dma_rvalid}); end
        checks++; if (bus.dma_rdata !== d2 || bus.cpu_rdata !== '0) begin errs++; $display("FAIL alt_rd2 got=%h/%h exp=0/%h", bus.cpu_rdata, bus.dma_rdata, d2); end
        adv();
    endtask

    task automatic test_reset_mid();
        set_in(1, 0, 16'h0010, '0, 1, 0, 16'h0011, '0);
        eval();
        adv();
        reset = 1'b0;
        m_clear();
        eval();
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errs++; $display("FAIL mid_rvalid got=%b exp=0", bus.cpu_rvalid); end
        checks++; if (u_dut.starve_cnt !== 4'd0) begin errs++; $display("FAIL mid_starve got=%0d exp=0", u_dut.starve_cnt); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errs++; $display("FAIL mid_stall got=%0d exp=0", bus.stall_cnt); end
        adv();
        set_in(0, 0, '0, '0, 0, 0, '0, '0);
        reset = 1'b1;
        eval();
        checks++; if ({bus.cpu_rvalid, bus.dma_rvalid} !== 2'b00) begin errs++; $display("FAIL mid_after got=%b exp=00", {bus.cpu_rvalid, bus.dma_rvalid}); end
        adv();
    endtask

    task automatic test_random();
        bit cr, cw, dr, dw;
        logic [AW-1:0] ca, da;
        logic [DW-1:0] cd, dd;
        int last = 0;
        cr = 0; dr = 0; cw = 0; dw = 0; ca = '0; da = '0; cd = '0; dd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(cr && last != 1)) begin
                cr = ($urandom_range(0, 3) != 0); cw = $urandom_range(0, 1);
                ca = AW'($urandom_range(0, 15)); cd = $urandom;
            end
            if (!(dr && last != 2)) begin
                dr = ($urandom_range(0, 2) != 0); dw = $urandom_range(0, 1);
                da = AW'($urandom_range(0, 15)); dd = $urandom;
            end
            set_in(cr, cw, ca, cd, dr, dw, da, dd);
            eval();
            checks++;
            if ({bus.cpu_gnt, bus.dma_gnt, bus.sram_EN, bus.sram_WE} !== {e_cgnt, e_dgnt, e_en, e_we}) begin
                errs++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, {bus.cpu_gnt, bus.dma_gnt, bus.sram_EN, bus.sram_WE}, {e_cgnt, e_dgnt, e_en, e_we});
            end
            checks++;
            if (bus.sram_ADDR !== e_addr || bus.sram_DI !== e_di) begin
                errs++; $display("FAIL rnd_bus cyc=%0d got=%h/%h exp=%h/%h", i, bus.sram_ADDR, bus.sram_DI, e_addr, e_di);
            end
            checks++;
            if ({bus.cpu_rvalid, bus.dma_rvalid} !== {e_crv, e_drv}) begin
                errs++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", i, {bus.cpu_rvalid, bus.dma_rvalid}, {e_crv, e_drv});
            end
            checks++;
            if (bus.cpu_rdata !== e_crd || bus.dma_rdata !== e_drd) begin
                errs++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", i, bus.cpu_rdata, bus.dma_rdata, e_crd, e_drd);
            end
            checks++;
            if (int'(bus.stall_cnt) !== m_stall) begin
                errs++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, bus.stall_cnt, m_stall);
            end
            last = win;
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_starvation();
        test_alternating();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
